// File: rtl/alu_slice_exec_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg : op codes, FSM states and defaults shared by the sliced ALU. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Unused codes 101..111 fall back to ADD.
  function automatic alu_op_e decode_op(input logic [2:0] code);
    case (code)
      3'b001:  return ALU_SUB;
      3'b010:  return ALU_AND;
      3'b011:  return ALU_OR;
      3'b100:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_slice_exec_if.sv
// ---------------------------------------------------------------------------
// alu_slice_exec_if : request/response handshake bundle of the sliced ALU. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface alu_slice_exec_if #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport slave (
    input  in_valid, ALUControl, srcA, srcB, out_ready,
    output in_ready, out_valid, result, zero
  );

  modport master (
    output in_valid, ALUControl, srcA, srcB, out_ready,
    input  in_ready, out_valid, result, zero
  );
endinterface

`default_nettype wire

// File: rtl/alu_slice_exec_slice.sv
// ---------------------------------------------------------------------------
// alu_slice : combinational SLICE-bit ALU cell with carry in/out. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  alu_op_e          op,
  input  logic             cin,
  output logic [SLICE-1:0] res,
  output logic             cout,
  output logic             msb_a,
  output logic             msb_b,
  output logic             msb_res
);

  logic [SLICE-1:0] b_eff;
  logic [SLICE:0]   sum;

  always_comb begin
    b_eff = (op == ALU_SUB || op == ALU_SLT) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{SLICE{1'b0}}, cin};
    res   = sum[SLICE-1:0];
    cout  = sum[SLICE];
    case (op)
      ALU_AND: begin res = a & b; cout = 1'b0; end
      ALU_OR:  begin res = a | b; cout = 1'b0; end
      default: ;
    endcase
  end

  // msb_res is the difference sign bit that SLT needs on the top slice.
  assign msb_a   = a[SLICE-1];
  assign msb_b   = b[SLICE-1];
  assign msb_res = sum[SLICE-1];

endmodule

`default_nettype wire

// File: rtl/alu_slice_exec.sv
// ---------------------------------------------------------------------------
// alu_slice_exec : multi-cycle ALU, one SLICE per cycle LSB first. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_slice_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_slice_exec_if.slave  bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  alu_state_e       state_q;
  alu_op_e          op_q;
  logic [WIDTH-1:0] a_q, b_q, result_q, result_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, zero_q;

  logic [SLICE-1:0] sl_a, sl_b, sl_res;
  logic             sl_cout, msb_a, msb_b, msb_res;
  alu_op_e          op_dec;

  assign op_dec = decode_op(bus.ALUControl);

  always_comb begin
    sl_a = a_q[SLICE-1:0];
    sl_b = b_q[SLICE-1:0];
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt_q == CW'(i)) begin
        sl_a = a_q[i*SLICE +: SLICE];
        sl_b = b_q[i*SLICE +: SLICE];
      end
    end
  end

  alu_slice #(.SLICE(SLICE)) u_slice (
    .a       (sl_a),
    .b       (sl_b),
    .op      (op_q),
    .cin     (carry_q),
    .res     (sl_res),
    .cout    (sl_cout),
    .msb_a   (msb_a),
    .msb_b   (msb_b),
    .msb_res (msb_res)
  );

  // On the top SLT slice the whole result collapses to the signed less-than bit.
  always_comb begin
    result_d = result_q;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt_q == CW'(i)) result_d[i*SLICE +: SLICE] = sl_res;
    end
    if (cnt_q == LAST && op_q == ALU_SLT) begin
      result_d    = '0;
      result_d[0] = (msb_a != msb_b) ? msb_a : msb_res;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= ALU_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_q      <= bus.srcA;
            b_q      <= bus.srcB;
            op_q     <= op_dec;
            carry_q  <= (op_dec == ALU_SUB || op_dec == ALU_SLT);
            cnt_q    <= '0;
            result_q <= '0;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          result_q <= result_d;
          carry_q  <= sl_cout;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            zero_q  <= (result_d == '0);
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

endmodule

`default_nettype wire

// File: doc/alu_slice_exec.md
Name: alu_slice_exec

Overview:
- Iterative ALU execution unit sitting directly downstream of the ALU control decoder. It consumes the 3-bit ALUControl code plus two operands.
- Processes operands SLICE bits per cycle, least significant slice first, with a carried ripple between slices.
- Presents a registered result and zero flag over a valid/ready handshake.
- Area-reduced replacement for a full-width combinational ALU. Also serves as the template for later multi-cycle execute units.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SLICE, 8, bits processed per cycle. Must divide WIDTH. NSLICE = WIDTH/SLICE.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operation request valid
- in_ready  output  1  unit can accept an operation (combinational from state)
- ALUControl  input  3  operation code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101-111 treated as ADD
- srcA  input  WIDTH  operand A
- srcB  input  WIDTH  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- zero  output  1  registered (result == 0)

Behaviour:
- Interface (decided): one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: state IDLE, out_valid 0, result 0, zero 0, slice counter 0, carry 0. in_ready is 1 in the first cycle after reset deasserts.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch srcA, srcB, op.
  - Set carry = 1 for SUB/SLT, else 0. Counter = 0. Go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, slice i = counter processes bits [i*SLICE +: SLICE].
  - ADD: a+b+carry. SUB/SLT: a+~b+carry. AND: a&b. OR: a|b.
  - Carry-out is registered into carry. The result slice is written into the result register. Counter increments.
  - When counter == NSLICE-1, go to DONE on the same edge.
  - SLT at the last slice: result = {0..., lt}, where lt = (a_msb != b_msb) ? a_msb : diff_msb. This is a signed compare.
  - zero is computed from the final full result and registered on the transition into DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - result and zero are held stable while !out_ready.
  - On out_ready, go to IDLE.
  - No new operation is accepted in the same cycle as output acceptance.
- Latency: an operation accepted at edge k gives out_valid=1 after edge k+NSLICE (4 edges for the defaults). Throughput is one operation per NSLICE+2 cycles at best.
- SLICE==WIDTH: RUN lasts one cycle, giving latency 1.
- out_valid is never high while in_ready is high.
- Inputs are ignored whenever in_ready=0. Operands are not sampled after acceptance.
- Width rules:
  - Final carry-out and overflow are discarded for ADD/SUB. Arithmetic wraps modulo 2^WIDTH.
  - result bits above the last written slice are cleared at acceptance.
- rst_n low in any state, including mid-RUN or DONE with the result unconsumed: all state returns to reset values on that edge. The pending operation is dropped and no out_valid is produced.
- out_ready asserted while out_valid=0 has no effect.

Decomposition:
- Package alu_pkg holds:
  - alu_op_e enum: ADD=3'b000, SUB=3'b001, AND=3'b010, OR=3'b011, SLT=3'b100.
  - Default ALU_WIDTH constant.
  - FSM state enum.
- Sub-module alu_slice: combinational SLICE-bit unit.
  - Inputs: a, b, op, cin.
  - Outputs: res, cout, msb_a, msb_b, msb_res.
  - Instantiated once and reused every RUN cycle via operand muxing by counter.

Test Plan:
1. ADD srcA=0x000000FF, srcB=0x00000001 -> result 0x00000100, zero 0. Carry crosses the slice 0/1 boundary. out_valid rises exactly 4 edges after acceptance.
2. SUB 0x00000005 - 0x00000005 -> result 0, zero 1. SUB 0x00000000 - 0x00000001 -> 0xFFFFFFFF, zero 0.
3. SLT 0xFFFFFFFF vs 0x00000001 -> result 1. SLT 0x7FFFFFFF vs 0x80000000 -> result 0. SLT 3 vs 3 -> result 0.
4. AND 0xF0F0F0F0 & 0x0FF00FF0 -> 0x00F000F0. OR on the same operands -> 0xFFF0FFF0. ALUControl=3'b111 with 2, 3 -> 5.
5. Backpressure: hold out_ready=0 for 3 cycles while driving a new in_valid -> result/zero stable, in_ready 0, new request ignored. After the out_ready handshake, IDLE is reached and the next request is accepted one cycle later.
6. rst_n=0 for one edge during RUN (counter=2) -> next cycle IDLE, out_valid 0, result 0, in_ready 1. A subsequent ADD 1+1 returns 2.
